// File: rtl/bias_act.sv
// rtl/bias_act.sv - chunked bias-add, rounding shift, ReLU and saturation stage
//
// Bias line c is BiasInit[c*WorkingRegs*BiasWidth +: WorkingRegs*BiasWidth];
// lane i within a line is bits [i*BiasWidth +: BiasWidth].
module bias_act #(
    parameter int InVecLength = 64,
    parameter int WorkingRegs = 8,
    parameter int InWidth     = 16,
    parameter int BiasWidth   = 8,
    parameter int OutWidth    = 8,
    parameter int Shift       = 4,
    parameter int ReluEn      = 1,
    parameter logic [InVecLength*BiasWidth-1:0] BiasInit = '0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WorkingRegs*InWidth-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WorkingRegs*OutWidth-1:0] out_data,
    output logic                            out_last,
    output logic                            out_sat
);

    localparam int NCH = InVecLength / WorkingRegs;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW  = WorkingRegs * BiasWidth;
    localparam int W   = ((InWidth > BiasWidth) ? InWidth : BiasWidth) + 2;

    localparam logic [PW-1:0]       LAST_PTR = PW'(NCH - 1);
    localparam logic signed [W-1:0] RND      = W'((Shift > 0) ? (2 ** (Shift - 1)) : 0);
    localparam logic signed [W-1:0] OMAX     = W'((2 ** (OutWidth - 1)) - 1);
    localparam logic signed [W-1:0] OMIN     = -W'(2 ** (OutWidth - 1));

    logic [PW-1:0]                  chunk_ptr;
    logic                           s1_valid;
    logic                           s1_last;
    logic [WorkingRegs*InWidth-1:0] s1_data;
    logic [RW-1:0]                  bias_q;
    logic                           out_adv;
    logic                           in_hs;
    logic [WorkingRegs*OutWidth-1:0] res_data;
    logic                           res_sat;

    // Handshake/advance logic; in_ready is held low while reset is asserted
    always_comb begin
        out_adv  = !out_valid || out_ready;
        in_ready = !rst_in && (!s1_valid || out_adv);
        in_hs    = in_valid && in_ready;
    end

    // Chunk counter and bias ROM read, both advancing on the input handshake
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            chunk_ptr <= '0;
            bias_q    <= '0;
        end else if (in_hs) begin
            chunk_ptr <= (chunk_ptr == LAST_PTR) ? '0 : chunk_ptr + 1'b1;
            bias_q    <= BiasInit[int'(chunk_ptr) * RW +: RW];
        end
    end

    // Stage 1: capture input lanes and last flag alongside the ROM output
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_hs) begin
                s1_data <= in_data;
                s1_last <= (chunk_ptr == LAST_PTR);
            end
        end
    end

    // Per-lane bias add, half-up rounding shift, ReLU, then signed saturation
    always_comb begin
        res_data = '0;
        res_sat  = 1'b0;
        for (int i = 0; i < WorkingRegs; i++) begin
            logic signed [W-1:0] s;
            s = W'(signed'(s1_data[i*InWidth +: InWidth]))
              + W'(signed'(bias_q[i*BiasWidth +: BiasWidth]));
            s = (s + RND) >>> Shift;
            if ((ReluEn != 0) && (s < 0)) begin
                s = '0;
            end
            if (s > OMAX) begin
                s       = OMAX;
                res_sat = 1'b1;
            end else if (s < OMIN) begin
                s       = OMIN;
                res_sat = 1'b1;
            end
            res_data[i*OutWidth +: OutWidth] = s[OutWidth-1:0];
        end
    end

    // Output register: loads from stage 1 whenever the output may advance
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_data;
                out_last <= s1_last;
                out_sat  <= res_sat;
            end
        end
    end

endmodule
